// File: rtl/led_symbol_shifter_pkg.sv
// rtl/led_symbol_shifter_pkg.sv - shared constants, strobe encoding and width helper for the LED symbol shifter
package led_shift_pkg;

  localparam int POL_DROP_OLDEST = 0;
  localparam int POL_REJECT      = 1;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_BKSP,
    OP_CLR
  } op_e;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int cnt_width(input int values);
    return (values <= 2) ? 1 : $clog2(values);
  endfunction

endpackage

// File: rtl/led_symbol_shifter_if.sv
// rtl/led_symbol_shifter_if.sv - strobe inputs and LED/status outputs of the symbol shifter
interface led_symbol_shifter_if #(
  parameter int WIDTH = 18,
  parameter int SYM_W = 4
);
  import led_shift_pkg::*;

  localparam int OCC_W = cnt_width(WIDTH + 1);
  localparam int BIT_W = cnt_width(SYM_W);

  logic             push;
  logic             n;
  logic             bksp;
  logic             clr;
  logic [WIDTH-1:0] led;
  logic [OCC_W-1:0] occ;
  logic [BIT_W-1:0] bit_cnt;
  logic             full;
  logic             empty;
  logic             sym_done;
  logic             reject;

  modport master (
    output push, n, bksp, clr,
    input  led, occ, bit_cnt, full, empty, sym_done, reject
  );

  modport slave (
    input  push, n, bksp, clr,
    output led, occ, bit_cnt, full, empty, sym_done, reject
  );

endinterface

// File: rtl/led_symbol_shifter.sv
// rtl/led_symbol_shifter.sv - serial bit entry into SYM_W-bit symbols with backspace, clear and full policy
module led_symbol_shifter
  import led_shift_pkg::*;
#(
  parameter int WIDTH       = 18,
  parameter int SYM_W       = 4,
  parameter int FULL_POLICY = POL_DROP_OLDEST
) (
  input  logic                 clk1,
  input  logic                 reset,
  led_symbol_shifter_if.slave  bus
);

  localparam int OCC_W = cnt_width(WIDTH + 1);
  localparam int BIT_W = cnt_width(SYM_W);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(WIDTH);
  localparam logic [OCC_W-1:0] OCC_SYM  = OCC_W'(SYM_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SYM_W - 1);

  generate
    if (WIDTH < SYM_W || SYM_W < 2) begin : g_bad_params
      $error("led_symbol_shifter: need WIDTH >= SYM_W and SYM_W >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] led_q, led_d;
  logic [OCC_W-1:0] occ_q, occ_d, k;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             sym_q, sym_d;
  logic             rej_q, rej_d;
  logic             full_w;
  op_e              op;

  assign full_w = (occ_q == OCC_FULL);

  always_comb begin
    op    = OP_IDLE;
    led_d = led_q;
    occ_d = occ_q;
    bit_d = bit_q;
    sym_d = 1'b0;
    rej_d = 1'b0;
    k     = '0;

    if (bus.clr)       op = OP_CLR;
    else if (bus.bksp) op = OP_BKSP;
    else if (bus.push) op = OP_PUSH;

    unique case (op)
      OP_CLR: begin
        led_d = '0;
        occ_d = '0;
        bit_d = '0;
      end
      OP_BKSP: begin
        if (occ_q == '0) begin
          rej_d = 1'b1;
        end else begin
          // A partial symbol goes first; otherwise a whole (possibly truncated) symbol.
          if (bit_q != '0)            k = OCC_W'(bit_q);
          else if (occ_q < OCC_SYM)   k = occ_q;
          else                        k = OCC_SYM;
          led_d = led_q >> k;
          occ_d = occ_q - k;
          bit_d = '0;
        end
      end
      OP_PUSH: begin
        if (full_w && FULL_POLICY == POL_REJECT) begin
          rej_d = 1'b1;
        end else begin
          led_d = {led_q[WIDTH-2:0], bus.n};
          if (!full_w) occ_d = occ_q + OCC_W'(1);
          bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
          sym_d = (bit_q == BIT_LAST);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      led_q <= '0;
      occ_q <= '0;
      bit_q <= '0;
      sym_q <= 1'b0;
      rej_q <= 1'b0;
    end else begin
      led_q <= led_d;
      occ_q <= occ_d;
      bit_q <= bit_d;
      sym_q <= sym_d;
      rej_q <= rej_d;
    end
  end

  assign bus.led      = led_q;
  assign bus.occ      = occ_q;
  assign bus.bit_cnt  = bit_q;
  assign bus.full     = full_w;
  assign bus.empty    = (occ_q == '0);
  assign bus.sym_done = sym_q;
  assign bus.reject   = rej_q;

endmodule

// File: tb/tb_led_symbol_shifter.sv
// tb/tb_led_symbol_shifter.sv - directed and random checks of both full policies against a bit-list model
module tb_led_symbol_shifter;

  localparam int W = 18;
  localparam int S = 4;

  logic clk1 = 1'b0;
  logic reset = 1'b1;
  logic push = 1'b0, n = 1'b0, bksp = 1'b0, clr = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk1 = ~clk1;

  led_symbol_shifter_if #(.WIDTH(W), .SYM_W(S)) bus0 ();
  led_symbol_shifter_if #(.WIDTH(W), .SYM_W(S)) bus1 ();

  assign bus0.push = push;
  assign bus0.n    = n;
  assign bus0.bksp = bksp;
  assign bus0.clr  = clr;
  assign bus1.push = push;
  assign bus1.n    = n;
  assign bus1.bksp = bksp;
  assign bus1.clr  = clr;

  led_symbol_shifter #(.WIDTH(W), .SYM_W(S), .FULL_POLICY(0)) dut0 (
    .clk1(clk1), .reset(reset), .bus(bus0));
  led_symbol_shifter #(.WIDTH(W), .SYM_W(S), .FULL_POLICY(1)) dut1 (
    .clk1(clk1), .reset(reset), .bus(bus1));

  // Model: the entered string as a list of bits, oldest first.
  bit mq[2][$];
  int mpart[2];
  bit msym[2];
  bit mrej[2];

  function automatic logic [31:0] model_led(input int p);
    logic [31:0] v = '0;
    int sz = mq[p].size();
    for (int i = 0; i < sz; i++) v[i] = mq[p][sz-1-i];
    return v;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      mq[p].delete();
      mpart[p] = 0;
      msym[p] = 0;
      mrej[p] = 0;
    end
  endtask

  task automatic model_step(input bit c, input bit b, input bit ps, input bit nv);
    for (int p = 0; p < 2; p++) begin
      msym[p] = 0;
      mrej[p] = 0;
      if (c) begin
        mq[p].delete();
        mpart[p] = 0;
      end else if (b) begin
        if (mq[p].size() == 0) mrej[p] = 1;
        else begin
          int k = (mpart[p] != 0) ? mpart[p] : ((mq[p].size() < S) ? mq[p].size() : S);
          repeat (k) void'(mq[p].pop_back());
          mpart[p] = 0;
        end
      end else if (ps) begin
        if (mq[p].size() == W && p == 1) mrej[p] = 1;
        else begin
          mq[p].push_back(nv);
          if (mq[p].size() > W) void'(mq[p].pop_front());
          mpart[p] = (mpart[p] + 1) % S;
          msym[p] = (mpart[p] == 0);
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    for (int p = 0; p < 2; p++) begin
      int sz = mq[p].size();
      check($sformatf("%s pol%0d led", where, p), 32'(p ? bus1.led : bus0.led), model_led(p));
      check($sformatf("%s pol%0d occ", where, p), 32'(p ? bus1.occ : bus0.occ), 32'(sz));
      check($sformatf("%s pol%0d bit_cnt", where, p), 32'(p ? bus1.bit_cnt : bus0.bit_cnt), 32'(mpart[p]));
      check($sformatf("%s pol%0d full", where, p), 32'(p ? bus1.full : bus0.full), 32'(sz == W));
      check($sformatf("%s pol%0d empty", where, p), 32'(p ? bus1.empty : bus0.empty), 32'(sz == 0));
      check($sformatf("%s pol%0d sym_done", where, p), 32'(p ? bus1.sym_done : bus0.sym_done), 32'(msym[p]));
      check($sformatf("%s pol%0d reject", where, p), 32'(p ? bus1.reject : bus0.reject), 32'(mrej[p]));
    end
  endtask

  task automatic step(input string where, input bit c, input bit b, input bit ps, input bit nv);
    @(negedge clk1);
    clr = c; bksp = b; push = ps; n = nv;
    @(posedge clk1);
    #1;
    model_step(c, b, ps, nv);
    clr = 0; bksp = 0; push = 0; n = 0;
    check_all(where);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    reset = 1'b0;
    #1;
    check_all("reset");
    step("idle", 0, 0, 0, 0);

    step("push1", 0, 0, 1, 1);
    step("push0", 0, 0, 1, 0);
    step("push1b", 0, 0, 1, 1);
    step("push1c", 0, 0, 1, 1);
    check("sym_b led", 32'(bus0.led), 32'h0000B);
    check("sym_b pulse", 32'(bus0.sym_done), 32'd1);
    step("after_sym", 0, 0, 0, 0);

    step("push11a", 0, 0, 1, 1);
    step("push11b", 0, 0, 1, 1);
    step("bksp_partial", 0, 1, 0, 0);
    check("bksp_partial occ", 32'(bus0.occ), 32'd4);
    step("bksp_symbol", 0, 1, 0, 0);
    check("bksp_symbol empty", 32'(bus1.empty), 32'd1);
    step("bksp_empty", 0, 1, 0, 0);
    check("bksp_empty reject", 32'(bus0.reject), 32'd1);

    step("clr0", 1, 0, 0, 0);
    for (int i = 0; i < W; i++) step("fill", 0, 0, 1, 1);
    step("push_full", 0, 0, 1, 0);
    check("drop led", 32'(bus0.led), 32'h3FFFE);
    check("drop bit_cnt", 32'(bus0.bit_cnt), 32'd3);
    check("rej led", 32'(bus1.led), 32'h3FFFF);
    check("rej bit_cnt", 32'(bus1.bit_cnt), 32'd2);
    check("rej pulse", 32'(bus1.reject), 32'd1);
    step("bksp_full", 0, 1, 0, 0);

    step("clr1", 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step("seven", 0, 0, 1, 1'($urandom_range(0, 1)));
    step("all_strobes", 1, 1, 1, 1);
    check("all_strobes led", 32'(bus0.led), 32'd0);

    for (int i = 0; i < 400; i++) begin
      bit c  = ($urandom_range(0, 99) < 3);
      bit b  = ($urandom_range(0, 9) < 2);
      bit ps = ($urandom_range(0, 9) < 7);
      step("random", c, b, ps, 1'($urandom_range(0, 1)));
    end

    step("clr2", 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step("nine", 0, 0, 1, 1'($urandom_range(0, 1)));
    check("nine occ", 32'(bus0.occ), 32'd9);
    @(negedge clk1);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    #1;
    reset = 1'b0;
    push = 1'b1;
    n = 1'b1;
    @(posedge clk1);
    #1;
    model_step(0, 0, 1, 1);
    push = 0; n = 0;
    check_all("first_after_reset");
    check("first_after_reset led", 32'(bus1.led), 32'h00001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
